// File: rtl/median_seq.sv
// median_seq: streaming N-sample median filter (MED compare/rotate chain plus its sequencer)

// med: ring of DATA_QTDE registers; shift-in on DSI, plain rotate on BYP, else compare-rotate
module med #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_QTDE  = 9
) (
   input  logic                  CLK,
   input  logic                  DSI,
   input  logic                  BYP,
   input  logic [DATA_WIDTH-1:0] DI,
   output logic [DATA_WIDTH-1:0] DO
);
   localparam int N = DATA_QTDE;
   logic [DATA_WIDTH-1:0] r [N];
   logic [DATA_WIDTH-1:0] hi, lo;
   assign hi = (r[N-1] > r[N-2]) ? r[N-1] : r[N-2];
   assign lo = (r[N-1] > r[N-2]) ? r[N-2] : r[N-1];
   assign DO = r[N-1];
   // last stage keeps the larger of itself and its predecessor; the smaller recirculates to the head
   always_ff @(posedge CLK) begin
      r[0] <= DSI ? DI : (BYP ? r[N-1] : lo);
      for (int i = 1; i < N - 1; i++) r[i] <= r[i-1];
      r[N-1] <= (DSI || BYP) ? r[N-2] : hi;
   end
endmodule

module median_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_QTDE  = 9
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  DSI,
   input  logic [DATA_WIDTH-1:0] DI,
   output logic [DATA_WIDTH-1:0] DO,
   output logic                  DSO,
   output logic                  BUSY
);
   localparam int N  = DATA_QTDE;
   localparam int P  = (N - 1) / 2;
   localparam int CW = $clog2(N + 1);
   localparam int PW = $clog2(P + 1);
   typedef enum logic [2:0] {IDLE, LOAD, COMPARE, BYPASS, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n, cyc, cyc_n;
   logic [PW-1:0] pass, pass_n;
   logic med_dsi, med_byp;
   med #(.DATA_WIDTH(DATA_WIDTH), .DATA_QTDE(DATA_QTDE)) u_med (
      .CLK(CLK),
      .DSI(med_dsi),
      .BYP(med_byp),
      .DI (DI),
      .DO (DO)
   );
   // state and counter registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         cyc   <= '0;
         pass  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cyc   <= cyc_n;
         pass  <= pass_n;
      end
   end
   // pass p: N-1-p compare cycles then p+1 rotate cycles, so the top p+1 values settle at the ring head
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cyc_n   = cyc;
      pass_n  = pass;
      BUSY    = (state == COMPARE) || (state == BYPASS);
      DSO     = (state == DONE);
      med_dsi = DSI && !BUSY;
      med_byp = (state != COMPARE);
      case (state)
         IDLE, DONE: begin
            state_n = DSI ? LOAD : IDLE;
            cnt_n   = DSI ? CW'(1) : '0;
         end
         LOAD:
            if (!DSI) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (int'(cnt) == N - 1) begin
               state_n = COMPARE;
               cnt_n   = '0;
               cyc_n   = '0;
               pass_n  = '0;
            end else
               cnt_n = cnt + 1'b1;
         COMPARE:
            if (int'(cyc) == N - 2 - int'(pass)) begin
               state_n = (int'(pass) < P) ? BYPASS : DONE;
               cyc_n   = '0;
            end else
               cyc_n = cyc + 1'b1;
         BYPASS:
            if (int'(cyc) == int'(pass)) begin
               state_n = COMPARE;
               cyc_n   = '0;
               pass_n  = pass + 1'b1;
            end else
               cyc_n = cyc + 1'b1;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_median_seq.sv
// tb_median_seq: scoreboard bench for median_seq
module tb_median_seq;
   localparam int W   = 8;
   localparam int N   = 9;
   localparam int P   = (N - 1) / 2;
   localparam int LAT = N * (P + 1) + N - 1 - P;
   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         DSI = 1'b0;
   logic [W-1:0] DI  = '0;
   logic [W-1:0] DO;
   logic         DSO, BUSY;
   int checks = 0, errors = 0, t = 0, dso_n = 0, dso_t = 0;
   int exp_q[$];
   int win[$];
   median_seq #(.DATA_WIDTH(W), .DATA_QTDE(N)) dut (
      .CLK (CLK),
      .RST (RST),
      .DSI (DSI),
      .DI  (DI),
      .DO  (DO),
      .DSO (DSO),
      .BUSY(BUSY)
   );
   always #5 CLK = ~CLK;
   // cycle index of the current clock period
   always @(posedge CLK) t <= t + 1;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic int ref_med();
      int a[$];
      int tmp;
      a = win;
      for (int i = 0; i < a.size(); i++)
         for (int j = 0; j < a.size() - 1 - i; j++)
            if (a[j] > a[j+1]) begin
               tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
            end
      return a[P];
   endfunction
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic load(input bit push);
      foreach (win[i]) begin
         DSI = 1'b1;
         DI  = W'(win[i]);
         step();
      end
      DSI = 1'b0;
      if (push) exp_q.push_back(ref_med());
   endtask
   task automatic rand_win(input int hi);
      win.delete();
      for (int i = 0; i < N; i++) win.push_back($urandom_range(0, hi));
   endtask
   task automatic drain(input string tag);
      for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) step();
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask
   // scoreboard: every DSO must match the oldest pending window median
   always @(negedge CLK)
      if (DSO === 1'b1) begin
         dso_n++;
         dso_t = t;
         if (exp_q.size() == 0) chk("unexpected_dso", 1, 0);
         else chk("median", int'(DO), exp_q.pop_front());
      end
   initial begin
      int t0, ta, n0, busy_n, early;
      RST = 1'b1;
      repeat (3) step();
      chk("rst_dso", int'(DSO), 0);
      chk("rst_busy", int'(BUSY), 0);
      DSI = 1'b1;
      DI  = 8'd200;
      step();
      chk("rst_dsi_busy", int'(BUSY), 0);
      RST = 1'b0;
      win = {1, 2, 3, 4, 5, 6, 7, 8, 9};
      t0 = t;
      load(1'b1);
      busy_n = 0;
      early  = 0;
      for (int c = N; c < LAT; c++) begin
         busy_n += int'(BUSY);
         early  += int'(DSO);
         step();
      end
      chk("busy_cycles", busy_n, LAT - N);
      chk("dso_early", early, 0);
      chk("dso_on_time", int'(DSO), 1);
      chk("busy_in_done", int'(BUSY), 0);
      step();
      chk("dso_one_cycle", int'(DSO), 0);
      chk("dso_cycle", dso_t - t0, LAT);
      drain("asc_drain");
      win = {255, 0, 7, 255, 7, 0, 7, 255, 0};
      load(1'b1);
      drain("dup_drain");
      win = {170, 170, 170, 170, 170, 170, 170, 170, 170};
      load(1'b1);
      drain("const_drain");
      n0 = dso_n;
      for (int i = 0; i < 4; i++) begin
         DSI = 1'b1;
         DI  = W'(i + 50);
         step();
      end
      DSI = 1'b0;
      step();
      chk("abort_busy", int'(BUSY), 0);
      repeat (LAT + 5) step();
      chk("abort_no_dso", dso_n - n0, 0);
      win = {9, 8, 7, 6, 5, 4, 3, 2, 1};
      load(1'b1);
      drain("desc_drain");
      rand_win(255);
      load(1'b1);
      for (int i = 0; i < 2 * LAT && DSO !== 1'b1; i++) step();
      chk("b2b_a_dso", int'(DSO), 1);
      ta = t;
      rand_win(255);
      load(1'b1);
      drain("b2b_drain");
      chk("b2b_period", dso_t - ta, LAT);
      n0 = dso_n;
      t0 = t;
      rand_win(255);
      load(1'b0);
      while (t - t0 < 20) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("rst_mid_busy", int'(BUSY), 0);
      chk("rst_mid_dso", int'(DSO), 0);
      repeat (LAT + 5) step();
      chk("rst_mid_no_dso", dso_n - n0, 0);
      rand_win(255);
      load(1'b1);
      for (int c = N; c < LAT; c++) begin
         DSI = 1'($urandom_range(0, 1));
         DI  = W'($urandom_range(0, 255));
         step();
      end
      DSI = 1'b0;
      drain("toggle_drain");
      for (int k = 0; k < 1000; k++) begin
         rand_win((k % 2 == 0) ? 255 : 3);
         load(1'b1);
         drain("rand_drain");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
